// File: rtl/adder_pkg.sv
// Shared definitions for the chunked wide adder slice.
//   WIDTH          : per-chunk adder width, chosen at compile time by ADDER_nBIT
//   CHUNKS_DEFAULT : default number of chunks per operand
//   cwa_state_t    : controller states of chunked_wide_adder
//   idx_width()    : width of the chunk index counter for a given chunk count
`ifndef ADDER_nBIT
`define ADDER_nBIT 4
`endif

package adder_pkg;

    localparam int WIDTH          = `ADDER_nBIT;
    localparam int CHUNKS_DEFAULT = 4;

    typedef enum logic [1:0] {IDLE, ADD, DONE} cwa_state_t;

    // A single-chunk build still needs a 1-bit index.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit combinational ripple-carry adder used as the per-chunk datapath.
//   a, b : chunk operands
//   cin  : carry into bit 0
//   sum  : a + b + cin (low WIDTH bits)
//   cout : carry out of bit WIDTH-1
module ripple_carry_adder
    import adder_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The carry is carried in a procedural variable so the chain is a plain
    // sequence of full adders rather than a self-referencing vector.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/chunked_wide_adder.sv
// Multi-cycle CHUNKS*WIDTH-bit adder that reuses one ripple_carry_adder,
// one WIDTH-bit chunk per cycle, least significant chunk first.
//   clk, rst             : clock and synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   sum                  : a + b + cin modulo 2^TW
//   cout                 : carry out of the top bit
//   ovf                  : signed overflow
//   busy                 : an operation is in progress or awaiting pickup
module chunked_wide_adder
    import adder_pkg::*;
#(
    parameter int CHUNKS = CHUNKS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHUNKS*WIDTH-1:0] a,
    input  logic [CHUNKS*WIDTH-1:0] b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHUNKS*WIDTH-1:0] sum,
    output logic                    cout,
    output logic                    ovf,
    output logic                    busy
);

    localparam int TW = CHUNKS * WIDTH;
    localparam int IW = idx_width(CHUNKS);
    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    cwa_state_t        state_reg, state_next;
    logic [TW-1:0]     a_sh_reg, b_sh_reg, sum_sh_reg, sum_reg;
    logic [IW-1:0]     idx_reg;
    logic              carry_reg, sign_a_reg, sign_b_reg;
    logic              cout_reg, ovf_reg;

    logic [WIDTH-1:0]  adder_sum;
    logic              adder_cout;
    logic [TW-1:0]     sum_sh_next;
    logic              accept;
    logic              last_chunk;

    ripple_carry_adder u_rca (
        .a    (a_sh_reg[WIDTH-1:0]),
        .b    (b_sh_reg[WIDTH-1:0]),
        .cin  (carry_reg),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    // New chunk results enter from the top so that after CHUNKS steps the
    // first chunk has reached the bottom of the register.
    generate
        if (CHUNKS == 1) begin : g_single
            assign sum_sh_next = adder_sum;
        end else begin : g_multi
            assign sum_sh_next = {adder_sum, sum_sh_reg[TW-1:WIDTH]};
        end
    endgenerate

    assign in_ready   = (state_reg == IDLE) && !rst;
    assign out_valid  = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx_reg == LAST_IDX);

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)     state_next = ADD;
            ADD:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            sum_reg    <= '0;
            idx_reg    <= '0;
            carry_reg  <= 1'b0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        carry_reg  <= cin;
                        sign_a_reg <= a[TW-1];
                        sign_b_reg <= b[TW-1];
                        idx_reg    <= '0;
                    end
                end
                ADD: begin
                    a_sh_reg   <= a_sh_reg >> WIDTH;
                    b_sh_reg   <= b_sh_reg >> WIDTH;
                    sum_sh_reg <= sum_sh_next;
                    carry_reg  <= adder_cout;
                    idx_reg    <= idx_reg + IW'(1);
                    if (last_chunk) begin
                        // Output registers only change here, so they stay
                        // stable through DONE and IDLE.
                        sum_reg  <= sum_sh_next;
                        cout_reg <= adder_cout;
                        ovf_reg  <= (sign_a_reg == sign_b_reg) &&
                                    (adder_sum[WIDTH-1] != sign_a_reg);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_wide_adder.sv
// Self-checking bench for chunked_wide_adder (CHUNKS=4, default WIDTH).
// Expected results come from plain wide arithmetic on the operands.
module tb_chunked_wide_adder;
    import adder_pkg::*;

    localparam int CH = 4;
    localparam int TW = CH * WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          cin = 1'b0;
    logic          out_ready = 1'b0;
    logic [TW-1:0] a = '0;
    logic [TW-1:0] b = '0;
    logic          in_ready, out_valid, cout, ovf, busy;
    logic [TW-1:0] sum;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    chunked_wide_adder #(.CHUNKS(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // {ovf, cout, sum} for x + y + c
    function automatic logic [TW+1:0] ref_add(input logic [TW-1:0] x,
                                              input logic [TW-1:0] y,
                                              input logic c);
        logic [TW:0] full;
        logic        ov;
        full = {1'b0, x} + {1'b0, y} + {{TW{1'b0}}, c};
        ov   = (x[TW-1] == y[TW-1]) && (full[TW-1] != x[TW-1]);
        return {ov, full};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_out_valid(input string tag, output int k);
        k = 1;
        @(negedge clk);
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input logic [TW-1:0] xa, input logic [TW-1:0] xb,
                          input logic xc, input bit chk_lat, input string tag);
        logic [TW+1:0] e;
        int k;
        int t;
        e = ref_add(xa, xb, xc);
        @(negedge clk);
        a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, " accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out_valid(tag, k);
        if (chk_lat) check({tag, " latency"}, 32'(k), 32'(CH + 1));
        check({tag, " sum"},  32'(sum),  32'(e[TW-1:0]));
        check({tag, " cout"}, 32'(cout), 32'(e[TW]));
        check({tag, " ovf"},  32'(ovf),  32'(e[TW+1]));
        $display("op %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d", tag, xa, xb, xc, sum, cout, ovf);
        @(posedge clk);
        #1;
        check({tag, " idle after pickup"}, 32'(busy), 32'd0);
    endtask

    task automatic stream(input int n, input bit rnd_ready, input bit chk_space, input string tag);
        logic [TW+1:0] expq[$];
        logic [TW+1:0] e;
        logic [TW-1:0] xa, xb;
        logic          xc;
        int sent, got, last_acc, budget;
        bit acc, pop;
        sent = 0; got = 0; last_acc = -1; budget = 0;
        xa = TW'($urandom); xb = TW'($urandom); xc = 1'($urandom);
        while (got < n && budget < n * 20 + 50) begin
            @(negedge clk);
            if (sent < n) begin
                a = xa; b = xb; cin = xc; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                if (expq.size() == 0) begin
                    check({tag, " unexpected result"}, 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check({tag, " result"}, 32'({ovf, cout, sum}), 32'(e));
                    $display("op %s #%0d: sum=%h cout=%0d ovf=%0d", tag, got, sum, cout, ovf);
                end
                got++;
            end
            if (acc) begin
                expq.push_back(ref_add(xa, xb, xc));
                if (chk_space && last_acc >= 0)
                    check({tag, " accept spacing"}, 32'(cyc - last_acc), 32'(CH + 2));
                last_acc = cyc;
                sent++;
                xa = TW'($urandom); xb = TW'($urandom); xc = 1'($urandom);
            end
            @(posedge clk);
            budget++;
        end
        #1 in_valid = 1'b0;
        check({tag, " results returned"}, 32'(got), 32'(n));
    endtask

    initial begin
        logic [TW+1:0] e1, e2;
        int k;
        int t;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst sum",       32'(sum),       32'd0);
        check("rst cout",      32'(cout),      32'd0);
        check("rst ovf",       32'(ovf),       32'd0);
        check("rst in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b1, "t1");
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b1, "t2");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "t3a");
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, "t3b");

        // Backpressure with a second operation waiting
        e1 = ref_add(16'h0F0F, 16'h00F0, 1'b1);
        e2 = ref_add(16'hA5A5, 16'h5A5A, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        a = 16'h0F0F; b = 16'h00F0; cin = 1'b1; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 a = 16'hA5A5; b = 16'h5A5A; cin = 1'b0;
        wait_out_valid("t4", k);
        for (int i = 0; i < 3; i++) begin
            check("t4 hold out_valid", 32'(out_valid), 32'd1);
            check("t4 hold sum",       32'(sum),       32'(e1[TW-1:0]));
            check("t4 hold cout",      32'(cout),      32'(e1[TW]));
            check("t4 hold in_ready",  32'(in_ready),  32'd0);
            if (i < 2) @(negedge clk);
        end
        $display("op t4 first: sum=%h cout=%0d held 3 cycles", sum, cout);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4 out_valid dropped", 32'(out_valid), 32'd0);
        check("t4 second pending",    32'(in_ready),  32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("t4 second accepted", 32'(busy), 32'd1);
        wait_out_valid("t4b", k);
        check("t4b result", 32'({ovf, cout, sum}), 32'(e2));
        $display("op t4 second: sum=%h cout=%0d ovf=%0d", sum, cout, ovf);
        @(posedge clk);

        // Reset during the second ADD cycle
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5 rst out_valid", 32'(out_valid), 32'd0);
        check("t5 rst sum",       32'(sum),       32'd0);
        check("t5 rst busy",      32'(busy),      32'd0);
        rst = 1'b0;
        $display("op t5: reset mid-add, operation discarded");
        run_op(16'h1234, 16'h1111, 1'b0, 1'b1, "t5b");

        // Back-to-back, then random operands with random backpressure
        stream(3, 1'b0, 1'b1, "t6");
        stream(25, 1'b1, 1'b0, "rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
